// File: rtl/vx_gpr_hazard_gate.sv
// vx_gpr_hazard_gate: per-warp register scoreboard that holds the ibuf head until its operands are free.
// It registers accepted instructions into an elastic slot for the operand stage and counts hazard stall cycles.
module vx_gpr_hazard_gate #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 64,
    parameter int DATAW     = 128,
    parameter int PERF_W    = 32,
    localparam int WIS_W    = $clog2(NUM_WARPS),
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ibuf_valid,
    input  logic [WIS_W-1:0]  ibuf_wis,
    input  logic              ibuf_wb,
    input  logic [RW-1:0]     ibuf_rd,
    input  logic [RW-1:0]     ibuf_rs1,
    input  logic [RW-1:0]     ibuf_rs2,
    input  logic [RW-1:0]     ibuf_rs3,
    input  logic [DATAW-1:0]  ibuf_data,
    output logic              ibuf_ready,
    output logic              op_valid,
    output logic [WIS_W-1:0]  op_wis,
    output logic              op_wb,
    output logic [RW-1:0]     op_rd,
    output logic [RW-1:0]     op_rs1,
    output logic [RW-1:0]     op_rs2,
    output logic [RW-1:0]     op_rs3,
    output logic [DATAW-1:0]  op_data,
    input  logic              op_ready,
    input  logic              wb_valid,
    input  logic [WIS_W-1:0]  wb_wis,
    input  logic [RW-1:0]     wb_rd,
    input  logic              wb_eop,
    output logic [PERF_W-1:0] perf_stalls
);
    localparam int PW = WIS_W + 1 + 4 * RW + DATAW;

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending_q, pending_d;
    logic [PW-1:0]     op_q, op_d;
    logic              op_valid_q, op_valid_d;
    logic [PERF_W-1:0] perf_q, perf_d;
    logic              hazard, fire_in, wb_set, wb_clr;

    always_comb begin
        hazard     = (pending_q[ibuf_wis][ibuf_rd] & ibuf_wb) | pending_q[ibuf_wis][ibuf_rs1]
                   | pending_q[ibuf_wis][ibuf_rs2] | pending_q[ibuf_wis][ibuf_rs3];
        ibuf_ready = reset_n & !hazard & (!op_valid_q | op_ready);
        fire_in    = ibuf_valid & ibuf_ready;
        wb_set     = fire_in & ibuf_wb & (ibuf_rd != '0);
        wb_clr     = wb_valid & wb_eop & (wb_rd != '0);
        pending_d  = pending_q;
        if (wb_clr) pending_d[wb_wis][wb_rd] = 1'b0;
        // set is applied after clear so a same-entry collision resolves to pending
        if (wb_set) pending_d[ibuf_wis][ibuf_rd] = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) pending_d[w][0] = 1'b0;
        op_valid_d = fire_in | (op_valid_q & !op_ready);
        op_d       = fire_in ? {ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_data} : op_q;
        perf_d     = perf_q + PERF_W'(ibuf_valid & hazard);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            op_q       <= '0;
            op_valid_q <= 1'b0;
            perf_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            perf_q     <= perf_d;
        end
    end

    assign op_valid    = op_valid_q;
    assign {op_wis, op_wb, op_rd, op_rs1, op_rs2, op_rs3, op_data} = op_q;
    assign perf_stalls = perf_q;

    a_clr_pending: assert property (@(posedge clk) disable iff (!reset_n)
        !(wb_clr && !pending_q[wb_wis][wb_rd]));
    a_set_clr_collide: assert property (@(posedge clk) disable iff (!reset_n)
        !(wb_set && wb_clr && wb_wis == ibuf_wis && wb_rd == ibuf_rd));
endmodule

// File: tb/tb_vx_gpr_hazard_gate.sv
// tb_vx_gpr_hazard_gate: directed bench with a payload scoreboard for the hazard gate.
module tb_vx_gpr_hazard_gate;
    localparam int PW = 2 + 1 + 4 * 6 + 128;

    logic         clk = 0, reset_n = 0;
    logic         ibuf_valid = 0, ibuf_wb = 0, ibuf_ready;
    logic [1:0]   ibuf_wis = 0, op_wis, wb_wis = 0;
    logic [5:0]   ibuf_rd = 0, ibuf_rs1 = 0, ibuf_rs2 = 0, ibuf_rs3 = 0, wb_rd = 0;
    logic [5:0]   op_rd, op_rs1, op_rs2, op_rs3;
    logic [127:0] ibuf_data = 0, op_data;
    logic         op_valid, op_wb, op_ready = 0, wb_valid = 0, wb_eop = 0;
    logic [31:0]  perf_stalls;
    logic [PW-1:0] q[$];
    int checks = 0, failures = 0;

    vx_gpr_hazard_gate dut (
        .clk(clk), .reset_n(reset_n),
        .ibuf_valid(ibuf_valid), .ibuf_wis(ibuf_wis), .ibuf_wb(ibuf_wb), .ibuf_rd(ibuf_rd),
        .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3), .ibuf_data(ibuf_data),
        .ibuf_ready(ibuf_ready), .op_valid(op_valid), .op_wis(op_wis), .op_wb(op_wb), .op_rd(op_rd),
        .op_rs1(op_rs1), .op_rs2(op_rs2), .op_rs3(op_rs3), .op_data(op_data), .op_ready(op_ready),
        .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] op_bits();
        return {op_wis, op_wb, op_rd, op_rs1, op_rs2, op_rs3, op_data};
    endfunction

    function automatic logic [PW-1:0] ibuf_bits();
        return {ibuf_wis, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3, ibuf_data};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] wis, input logic wb,
                         input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rs3);
        ibuf_valid = v; ibuf_wis = wis; ibuf_wb = wb; ibuf_rd = rd;
        ibuf_rs1 = rs1; ibuf_rs2 = rs2; ibuf_rs3 = rs3;
        ibuf_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // samples the pre-edge handshake, scores the output slot, then advances one clock
    task automatic tick();
        #1;
        if (op_valid) begin
            if (q.size() == 0) check("sb_underflow", 256'(q.size()), 256'd1);
            else begin
                check("sb_payload", op_bits(), q[0]);
                if (op_ready) void'(q.pop_front());
            end
        end
        if (ibuf_valid && ibuf_ready) q.push_back(ibuf_bits());
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        check("rst_ready", ibuf_ready, 0);
        check("rst_opv", op_valid, 0);
        check("rst_perf", perf_stalls, 0);
        check("rst_payload", op_bits(), 0);
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
        // 1: basic issue marks w0 r5 pending
        op_ready = 1;
        drive(1, 0, 1, 5, 1, 2, 0); #1;
        check("t1_ready", ibuf_ready, 1);
        tick();
        check("t1_opv", op_valid, 1);
        // 2: RAW stall on w0 r5, cleared by eop writeback
        drive(1, 0, 1, 6, 5, 0, 0); #1;
        check("t2_ready", ibuf_ready, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t2_perf", perf_stalls, 256'(i));
            check("t2_ready_stall", ibuf_ready, 0);
        end
        wb_valid = 1; wb_eop = 1; wb_wis = 0; wb_rd = 5; #1;
        check("t2_ready_wbcycle", ibuf_ready, 0);
        tick();
        wb_valid = 0; wb_eop = 0; #1;
        check("t2_ready_after_clr", ibuf_ready, 1);
        check("t2_perf4", perf_stalls, 4);
        tick();
        check("t2_opv", op_valid, 1);
        // 3: per-warp isolation
        drive(1, 0, 1, 5, 0, 0, 0); #1;
        check("t3_ready_w0", ibuf_ready, 1);
        tick();
        drive(1, 1, 1, 5, 5, 0, 0); #1;
        check("t3_ready_w1", ibuf_ready, 1);
        tick();
        drive(1, 0, 0, 0, 5, 0, 0); #1;
        check("t3_raw_w0", ibuf_ready, 0);
        drive(1, 0, 1, 6, 0, 0, 0); #1;
        check("t3_waw_w0", ibuf_ready, 0);
        drive(1, 0, 0, 6, 0, 0, 0); #1;
        check("t3_nowb_rd", ibuf_ready, 1);
        // 4: backpressure holds the slot
        op_ready = 0;
        drive(1, 2, 0, 0, 3, 0, 0); #1;
        check("t4_ready_bp", ibuf_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_opv_hold", op_valid, 1);
            check("t4_ready_hold", ibuf_ready, 0);
        end
        op_ready = 1; #1;
        check("t4_ready_release", ibuf_ready, 1);
        tick();
        drive(1, 3, 0, 0, 0, 0, 0); #1;
        check("t4_ready_b2b", ibuf_ready, 1);
        tick();
        check("t4_opv_b2b", op_valid, 1);
        // 5: rd=0 never pends; non-eop beat leaves table alone
        for (int i = 0; i < 4; i++) begin
            drive(1, 2, 1, 0, 0, 0, 0); #1;
            check("t5_ready_rd0", ibuf_ready, 1);
            tick();
        end
        ibuf_valid = 0;
        wb_valid = 1; wb_eop = 0; wb_wis = 0; wb_rd = 5;
        tick();
        wb_valid = 0;
        check("t5_opv_idle", op_valid, 0);
        check("t5_perf", perf_stalls, 4);
        drive(1, 0, 0, 0, 5, 0, 0); #1;
        check("t5_still_pending", ibuf_ready, 0);
        // 6: async reset mid-flight
        drive(1, 3, 1, 7, 0, 0, 0); #1;
        check("t6_ready", ibuf_ready, 1);
        tick();
        check("t6_opv", op_valid, 1);
        ibuf_valid = 0; op_ready = 0; #2;
        reset_n = 0; #1;
        check("t6_rst_opv", op_valid, 0);
        check("t6_rst_perf", perf_stalls, 0);
        check("t6_rst_payload", op_bits(), 0);
        check("t6_rst_ready", ibuf_ready, 0);
        q.delete();
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
        op_ready = 1;
        drive(1, 0, 1, 6, 5, 0, 0); #1;
        check("t6_clr_w0", ibuf_ready, 1);
        drive(1, 1, 0, 0, 5, 0, 0); #1;
        check("t6_clr_w1", ibuf_ready, 1);
        drive(1, 3, 1, 7, 0, 0, 0); #1;
        check("t6_clr_w3", ibuf_ready, 1);
        tick();
        check("t6_opv_post", op_valid, 1);
        ibuf_valid = 0;
        tick();
        check("sb_drained", 256'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
